// File: rtl/census_pkg.sv
// Shared census-pipeline definitions: neighbour count, window slot indices and
// the window generator's frame-tracking state type.
package census_pkg;

   localparam int CENSUS_NEIGHBOURS = 8;

   // Row-major 3x3 neighbourhood with the centre left out
   localparam int SLOT_TL = 0;
   localparam int SLOT_T  = 1;
   localparam int SLOT_TR = 2;
   localparam int SLOT_L  = 3;
   localparam int SLOT_R  = 4;
   localparam int SLOT_BL = 5;
   localparam int SLOT_B  = 6;
   localparam int SLOT_BR = 7;

   typedef enum logic [1:0] {
      IDLE,
      PRIME,
      STREAM
   } census_state_t;

endpackage

// File: rtl/census_line_buf.sv
// Single-line pixel store: one write and one registered read per cycle.
// A read and a write to the same address return the old word.
module census_line_buf #(
   parameter int DEPTH = 384,
   parameter int WIDTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      rd_data <= mem[rd_addr];
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

endmodule

// File: rtl/census_window_gen.sv
// Raster-scan 3x3 window generator feeding census_transform.
// Define CENSUS_WIN_COORD_EN to add out_x/out_y centre coordinate ports.
module census_window_gen
   import census_pkg::*;
#(
   parameter int IMG_WIDTH   = 384,
   parameter int IMG_HEIGHT  = 288,
   parameter int BIT_WIDTH   = 8,
   parameter int WINDOW_SIZE = 3
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [BIT_WIDTH-1:0]                   in_pixel,
   input  logic                                   in_sof,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   output logic [BIT_WIDTH-1:0]                   center_pixel,
   output logic [CENSUS_NEIGHBOURS*BIT_WIDTH-1:0] window_pixels_flat,
   output logic                                   out_valid,
   input  logic                                   out_ready,
`ifdef CENSUS_WIN_COORD_EN
   output logic                                   out_eof,
   output logic [$clog2(IMG_WIDTH)-1:0]           out_x,
   output logic [$clog2(IMG_HEIGHT)-1:0]          out_y
`else
   output logic                                   out_eof
`endif
);

   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
   localparam logic [CW-1:0] COL_ONE  = CW'(1);
   localparam logic [CW-1:0] COL_TWO  = CW'(2);
   localparam logic [RW-1:0] ROW_ONE  = RW'(1);
   localparam logic [RW-1:0] ROW_TWO  = RW'(2);

   generate
      if (WINDOW_SIZE != 3) begin : g_bad_window_size
         $error("census_window_gen: WINDOW_SIZE must be 3");
      end
   endgenerate

   census_state_t          state_reg, state_next;
   logic [CW-1:0]          col_reg, col_next, eff_col;
   logic [RW-1:0]          row_reg, row_next, eff_row;
   logic                   accept, frame_px, emit, col_last, row_last;
   logic [BIT_WIDTH-1:0]   rd_top, rd_mid;
   logic [BIT_WIDTH-1:0]   mid_col_reg  [3];
   logic [BIT_WIDTH-1:0]   left_col_reg [3];
   logic [BIT_WIDTH-1:0]   slot_next    [CENSUS_NEIGHBOURS];
   logic [BIT_WIDTH-1:0]   win_reg      [CENSUS_NEIGHBOURS];

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   // Outside a frame only an in_sof pixel is kept; everything else is dropped
   assign frame_px = accept && (in_sof || state_reg != IDLE);
   assign eff_col  = in_sof ? '0 : col_reg;
   assign eff_row  = in_sof ? '0 : row_reg;
   assign col_last = (eff_col == COL_LAST);
   assign row_last = (eff_row == ROW_LAST);
   assign emit     = frame_px && !in_sof && state_reg == STREAM &&
                     row_reg >= ROW_TWO && col_reg >= COL_TWO;

   always_comb begin
      state_next = state_reg;
      col_next   = col_reg;
      row_next   = row_reg;
      if (frame_px) begin
         if (col_last) begin
            col_next = '0;
            row_next = row_last ? '0 : eff_row + ROW_ONE;
         end else begin
            col_next = eff_col + COL_ONE;
            row_next = eff_row;
         end
         if (in_sof) begin
            state_next = PRIME;
         end else if (state_reg == PRIME && eff_row == ROW_ONE && col_last) begin
            state_next = STREAM;
         end else if (state_reg == STREAM && row_last && col_last) begin
            state_next = IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         col_reg   <= '0;
         row_reg   <= '0;
      end else begin
         state_reg <= state_next;
         col_reg   <= col_next;
         row_reg   <= row_next;
      end
   end

   // Reads are addressed by the next column so the word for the coming
   // pixel is already on rd_data when that pixel is accepted.
   census_line_buf #(.DEPTH(IMG_WIDTH), .WIDTH(BIT_WIDTH)) u_buf_mid (
      .clk     (clk),
      .wr_en   (frame_px),
      .wr_addr (eff_col),
      .wr_data (in_pixel),
      .rd_addr (col_next),
      .rd_data (rd_mid)
   );

   census_line_buf #(.DEPTH(IMG_WIDTH), .WIDTH(BIT_WIDTH)) u_buf_top (
      .clk     (clk),
      .wr_en   (frame_px),
      .wr_addr (eff_col),
      .wr_data (rd_mid),
      .rd_addr (col_next),
      .rd_data (rd_top)
   );

   // Column shift registers: index 0 = top row, 1 = middle, 2 = bottom
   always_ff @(posedge clk) begin
      if (frame_px) begin
         mid_col_reg[0]  <= rd_top;
         mid_col_reg[1]  <= rd_mid;
         mid_col_reg[2]  <= in_pixel;
         left_col_reg    <= mid_col_reg;
      end
   end

   always_comb begin
      slot_next[SLOT_TL] = left_col_reg[0];
      slot_next[SLOT_T]  = mid_col_reg[0];
      slot_next[SLOT_TR] = rd_top;
      slot_next[SLOT_L]  = left_col_reg[1];
      slot_next[SLOT_R]  = rd_mid;
      slot_next[SLOT_BL] = left_col_reg[2];
      slot_next[SLOT_B]  = mid_col_reg[2];
      slot_next[SLOT_BR] = in_pixel;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid    <= 1'b0;
         out_eof      <= 1'b0;
         center_pixel <= '0;
         for (int k = 0; k < CENSUS_NEIGHBOURS; k++) begin
            win_reg[k] <= '0;
         end
      end else if (emit) begin
         out_valid    <= 1'b1;
         out_eof      <= row_last && col_last;
         center_pixel <= mid_col_reg[1];
         for (int k = 0; k < CENSUS_NEIGHBOURS; k++) begin
            win_reg[k] <= slot_next[k];
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
         out_eof   <= 1'b0;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < CENSUS_NEIGHBOURS; gi++) begin : g_pack
         assign window_pixels_flat[(gi+1)*BIT_WIDTH-1 -: BIT_WIDTH] = win_reg[gi];
      end
   endgenerate

`ifdef CENSUS_WIN_COORD_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         out_x <= '0;
         out_y <= '0;
      end else if (emit) begin
         out_x <= eff_col - COL_ONE;
         out_y <= eff_row - ROW_ONE;
      end
   end
`endif

endmodule

// File: tb/tb_census_window_gen.sv
// Directed bench for census_window_gen on a 5x4 image: ramp, uniform,
// back-pressure, frame abort, dropped pixels and mid-frame reset.
module tb_census_window_gen;

   localparam int W  = 5;
   localparam int H  = 4;
   localparam int BW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [BW-1:0] in_pixel = '0;
   logic          in_sof = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [BW-1:0] center_pixel;
   logic [63:0]   window_pixels_flat;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic          out_eof;
`ifdef CENSUS_WIN_COORD_EN
   logic [2:0]    out_x;
   logic [1:0]    out_y;
`endif

   always #5 clk = ~clk;

   census_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .BIT_WIDTH(BW), .WINDOW_SIZE(3)) dut (
      .clk                (clk),
      .rst                (rst),
      .in_pixel           (in_pixel),
      .in_sof             (in_sof),
      .in_valid           (in_valid),
      .in_ready           (in_ready),
      .center_pixel       (center_pixel),
      .window_pixels_flat (window_pixels_flat),
      .out_valid          (out_valid),
      .out_ready          (out_ready),
`ifdef CENSUS_WIN_COORD_EN
      .out_eof            (out_eof),
      .out_x              (out_x),
      .out_y              (out_y)
`else
      .out_eof            (out_eof)
`endif
   );

   logic [7:0]  cq[$];
   logic [63:0] fq[$];
   logic        eq[$];
   int          ec[$];
   logic [63:0] ef[$];
   logic        ee[$];
`ifdef CENSUS_WIN_COORD_EN
   int          xq[$];
   int          yq[$];
`endif
   int n_checks = 0;
   int n_pass   = 0;

   // Each negedge with a pending handshake is one delivered window
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         cq.push_back(center_pixel);
         fq.push_back(window_pixels_flat);
         eq.push_back(out_eof);
`ifdef CENSUS_WIN_COORD_EN
         xq.push_back(int'(out_x));
         yq.push_back(int'(out_y));
`endif
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   function automatic int pix(input int idx);
      return 10 * (idx / W) + (idx % W);
   endfunction

   // Ramp image 10*r+c: neighbour of centre v at (dy,dx) is v + 10*dy + dx
   function automatic logic [63:0] ramp_flat(input int v);
      int off[8] = '{-11, -10, -9, -1, 1, 9, 10, 11};
      logic [63:0] r;
      r = '0;
      for (int k = 0; k < 8; k++) r[k*8 +: 8] = 8'(v + off[k]);
      return r;
   endfunction

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] px, input logic sof);
      int waited;
      waited   = 0;
      in_pixel = px;
      in_sof   = sof;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         n_checks++;
         $error("FAIL send_timeout observed in_ready=%0d expected=1", in_ready);
      end
      sync();
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   task automatic send_range(input int a, input int b, input bit with_sof);
      for (int idx = a; idx <= b; idx++) send(8'(pix(idx)), with_sof && idx == 0);
   endtask

   task automatic idle(input int n);
      repeat (n) sync();
   endtask

   task automatic clear_q();
      cq.delete(); fq.delete(); eq.delete();
      ec.delete(); ef.delete(); ee.delete();
`ifdef CENSUS_WIN_COORD_EN
      xq.delete(); yq.delete();
`endif
   endtask

   task automatic exp_ramp(input int v, input logic eof);
      ec.push_back(v);
      ef.push_back(ramp_flat(v));
      ee.push_back(eof);
   endtask

   task automatic compare_all(input string tag);
      check($sformatf("%s_count", tag), 64'(cq.size()), 64'(ec.size()));
      for (int i = 0; i < ec.size() && i < cq.size(); i++) begin
         check($sformatf("%s_centre%0d", tag, i), 64'(cq[i]), 64'(ec[i]));
         check($sformatf("%s_flat%0d", tag, i), fq[i], ef[i]);
         check($sformatf("%s_eof%0d", tag, i), 64'(eq[i]), 64'(ee[i]));
      end
   endtask

   initial begin
      // Reset state
      idle(3);
      rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_eof", 64'(out_eof), 64'(0));
      check("rst_center", 64'(center_pixel), 64'(0));
      check("rst_flat", window_pixels_flat, 64'(0));
      check("rst_in_ready", 64'(in_ready), 64'(1));
      sync();

      // Pixels without in_sof after reset are swallowed
      clear_q();
      send_range(1, 12, 1'b0);
      idle(3);
      compare_all("nosof");

      // Ramp frame, full throughput, with a 1-cycle latency spot check
      clear_q();
      send_range(0, 12, 1'b1);
      @(negedge clk);
      check("lat_out_valid", 64'(out_valid), 64'(1));
      check("lat_center", 64'(center_pixel), 64'(11));
      check("lat_flat", window_pixels_flat, 64'h1615140C0A020100);
      sync();
      send_range(13, 19, 1'b0);
      idle(3);
      exp_ramp(11, 0); exp_ramp(12, 0); exp_ramp(13, 0);
      exp_ramp(21, 0); exp_ramp(22, 0); exp_ramp(23, 1);
      compare_all("ramp");
`ifdef CENSUS_WIN_COORD_EN
      for (int i = 0; i < ec.size() && i < xq.size(); i++) begin
         check($sformatf("ramp_x%0d", i), 64'(xq[i]), 64'(ec[i] % 10));
         check($sformatf("ramp_y%0d", i), 64'(yq[i]), 64'(ec[i] / 10));
      end
`endif

      // Uniform frame
      clear_q();
      for (int idx = 0; idx < W * H; idx++) send(8'd100, idx == 0);
      idle(3);
      for (int i = 0; i < 6; i++) begin
         ec.push_back(100);
         ef.push_back({8{8'd100}});
         ee.push_back(i == 5);
      end
      compare_all("uniform");

      // Back-pressure for 3 cycles while a window is pending
      clear_q();
      send_range(0, 12, 1'b1);
      out_ready = 1'b0;
      in_pixel  = 8'(pix(13));
      in_valid  = 1'b1;
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         check($sformatf("stall_in_ready%0d", s), 64'(in_ready), 64'(0));
         check($sformatf("stall_valid%0d", s), 64'(out_valid), 64'(1));
         check($sformatf("stall_center%0d", s), 64'(center_pixel), 64'(11));
         sync();
      end
      out_ready = 1'b1;
      send(8'(pix(13)), 1'b0);
      send_range(14, 19, 1'b0);
      idle(3);
      exp_ramp(11, 0); exp_ramp(12, 0); exp_ramp(13, 0);
      exp_ramp(21, 0); exp_ramp(22, 0); exp_ramp(23, 1);
      compare_all("stall");

      // in_sof at (2,3) aborts; that pixel becomes (0,0) of a fresh frame
      clear_q();
      send_range(0, 12, 1'b1);
      send(8'd0, 1'b1);
      send_range(1, 19, 1'b0);
      idle(3);
      exp_ramp(11, 0);
      exp_ramp(11, 0); exp_ramp(12, 0); exp_ramp(13, 0);
      exp_ramp(21, 0); exp_ramp(22, 0); exp_ramp(23, 1);
      compare_all("abort");

      // Reset while a window is held, then no windows without in_sof
      clear_q();
      out_ready = 1'b0;
      send_range(0, 12, 1'b1);
      rst = 1'b1;
      sync();
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_valid", 64'(out_valid), 64'(0));
      check("mid_rst_center", 64'(center_pixel), 64'(0));
      check("mid_rst_flat", window_pixels_flat, 64'(0));
      check("mid_rst_in_ready", 64'(in_ready), 64'(1));
      sync();
      out_ready = 1'b1;
      send_range(13, 19, 1'b0);
      idle(3);
      compare_all("post_rst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
